// File: rtl/sd_sector_xfer.sv
// sd_sector_xfer
//   Moves one SD sector between the SPI byte engine and PDP-8 DMA.
//   Each DMA word travels on the wire as a big-endian 16-bit byte pair.
//   The unused upper wire bits are sent as zero and ignored on receive.
//   A small word FIFO decouples the byte stream from DMA.
//   A transfer may cover only part of a sector. On read, the rest of the
//   sector is consumed and discarded. On write, the rest is padded with zero bytes.
//
//   Optional feature macro: SD_XFER_CRC_EN
//     When defined, a CRC16-CCITT (poly 0x1021, init 0x0000) covers the
//     512 data bytes. A write appends the two CRC bytes MSB first. A read
//     consumes two CRC bytes and flags crc_err on a mismatch.
//     When undefined, no CRC bytes are sent or consumed and crc_err is 0.
//
// Ports
//   clk, reset       clock, asynchronous active-high reset
//   clear            synchronous abort back to idle (IOCLR)
//   start/dir        command strobe (taken only when idle); dir 0=read, 1=write
//   mem_addr, len    first DMA address; word count (0 or >SECTOR_WORDS = full sector)
//   dmaDIN/dmaDOUT   memory data in (grant cycle) / out
//   dmaADDR          current DMA address, wraps modulo 2**ADDR_W
//   dmaRD/dmaWR      DMA read / write strobes in a request+grant cycle
//   dmaREQ/dmaGNT    DMA request / grant
//   rx_*             received byte stream (valid/ready)
//   tx_*             transmitted byte stream (valid/ready)
//   busy, done       not idle; single-cycle completion pulse
//   crc_err          read CRC mismatch, held until the next start
module sd_sector_xfer #(
    parameter int WORD_W       = 12,
    parameter int ADDR_W       = 15,
    parameter int SECTOR_WORDS = 256,
    parameter int FIFO_DEPTH   = 8,
    parameter int LEN_W        = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              start,
    input  logic              dir,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [LEN_W-1:0]  len,
    input  logic [WORD_W-1:0] dmaDIN,
    output logic [WORD_W-1:0] dmaDOUT,
    output logic [ADDR_W-1:0] dmaADDR,
    output logic              dmaRD,
    output logic              dmaWR,
    output logic              dmaREQ,
    input  logic              dmaGNT,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done,
    output logic              crc_err
);
    localparam int PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [LEN_W-1:0] W_SECT  = LEN_W'(SECTOR_WORDS);
    localparam logic [PTR_W:0]   W_DEPTH = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_XFER  = 3'd1,
        S_RD_DRAIN = 3'd2,
        S_RD_CRC   = 3'd3,
        S_WR_XFER  = 3'd4,
        S_WR_PAD   = 3'd5,
        S_WR_CRC   = 3'd6,
        S_DONE     = 3'd7
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [LEN_W-1:0]    r_len;        // effective word count of this transfer
    logic [LEN_W-1:0]    r_dma_cnt;    // words moved over DMA
    logic [LEN_W-1:0]    r_wire_cnt;   // data words moved over the byte stream
    logic                r_byte_ph;    // 0: high byte next, 1: low byte next
    logic [7:0]          r_rx_hi;
    logic [ADDR_W-1:0]   r_addr;
    logic [WORD_W-1:0]   r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wp;
    logic [PTR_W-1:0]    r_rp;
    logic [PTR_W:0]      r_cnt;

    logic                w_full;
    logic                w_empty;
    logic                w_more;
    logic                w_data_ph;
    logic [LEN_W-1:0]    w_len_eff;
    logic [WORD_W-1:0]   w_head;
    logic [15:0]         w_head16;
    logic [WORD_W-1:0]   w_rx_word;
    logic                w_rx_fire;
    logic                w_tx_fire;
    logic                w_dma_fire;
    logic                w_push;
    logic                w_pop;

`ifdef SD_XFER_CRC_EN
    logic [15:0]         r_crc;
    logic                r_crc_err;
`endif

    assign w_full     = (r_cnt == W_DEPTH);
    assign w_empty    = (r_cnt == {(PTR_W + 1){1'b0}});
    assign w_more     = (r_wire_cnt < W_SECT);
    assign w_len_eff  = ((len == {LEN_W{1'b0}}) || (len > W_SECT)) ? W_SECT : len;
    assign w_head     = r_mem[r_rp];
    assign w_head16   = 16'(w_head);
    // Upper wire bits beyond WORD_W are dropped here.
    assign w_rx_word  = WORD_W'({r_rx_hi, rx_data});
    assign w_rx_fire  = rx_valid && rx_ready;
    assign w_tx_fire  = tx_valid && tx_ready;
    assign w_dma_fire = dmaREQ && dmaGNT;
    assign w_data_ph  = (r_state == S_RD_XFER) || (r_state == S_RD_DRAIN) ||
                        (r_state == S_WR_XFER) || (r_state == S_WR_PAD);
    assign w_push     = ((r_state == S_RD_XFER) && w_rx_fire && r_byte_ph) ||
                        ((r_state == S_WR_XFER) && w_dma_fire);
    assign w_pop      = ((r_state == S_RD_XFER) && w_dma_fire) ||
                        ((r_state == S_WR_XFER) && w_tx_fire && r_byte_ph);
    assign dmaADDR    = r_addr;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else if (clear) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = dir ? S_WR_XFER : S_RD_XFER;
                else       w_next = S_IDLE;
            end
            S_RD_XFER: begin
                if (w_dma_fire && (r_dma_cnt == (r_len - LEN_W'(1)))) w_next = S_RD_DRAIN;
                else                                                  w_next = S_RD_XFER;
            end
            S_RD_DRAIN: begin
`ifdef SD_XFER_CRC_EN
                if (!w_more) w_next = S_RD_CRC;
`else
                if (!w_more) w_next = S_DONE;
`endif
                else         w_next = S_RD_DRAIN;
            end
            S_RD_CRC: begin
                if (w_rx_fire && r_byte_ph) w_next = S_DONE;
                else                        w_next = S_RD_CRC;
            end
            S_WR_XFER: begin
                if (r_wire_cnt == r_len) w_next = S_WR_PAD;
                else                     w_next = S_WR_XFER;
            end
            S_WR_PAD: begin
`ifdef SD_XFER_CRC_EN
                if (!w_more) w_next = S_WR_CRC;
`else
                if (!w_more) w_next = S_DONE;
`endif
                else         w_next = S_WR_PAD;
            end
            S_WR_CRC: begin
                if (w_tx_fire && r_byte_ph) w_next = S_DONE;
                else                        w_next = S_WR_CRC;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output decode; strobes follow request/grant in the same cycle.
    always_comb begin
        dmaREQ   = 1'b0;
        dmaRD    = 1'b0;
        dmaWR    = 1'b0;
        dmaDOUT  = {WORD_W{1'b0}};
        rx_ready = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        busy     = (r_state != S_IDLE);
        done     = (r_state == S_DONE);
        case (r_state)
            S_RD_XFER: begin
                rx_ready = !w_full && w_more;
                dmaREQ   = !w_empty && (r_dma_cnt < r_len);
                dmaWR    = dmaREQ && dmaGNT;
                if (dmaWR) dmaDOUT = w_head;
                else       dmaDOUT = {WORD_W{1'b0}};
            end
            S_RD_DRAIN: rx_ready = w_more;
            S_RD_CRC:   rx_ready = 1'b1;
            S_WR_XFER: begin
                dmaREQ   = !w_full && (r_dma_cnt < r_len);
                dmaRD    = dmaREQ && dmaGNT;
                tx_valid = !w_empty;
                if (!tx_valid)      tx_data = 8'h00;
                else if (r_byte_ph) tx_data = w_head16[7:0];
                else                tx_data = w_head16[15:8];
            end
            S_WR_PAD:   tx_valid = w_more;
`ifdef SD_XFER_CRC_EN
            S_WR_CRC: begin
                tx_valid = 1'b1;
                if (r_byte_ph) tx_data = r_crc[7:0];
                else           tx_data = r_crc[15:8];
            end
`endif
            default: begin
                dmaREQ = 1'b0;
            end
        endcase
    end

    // Command capture, address and word/byte counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_len      <= {LEN_W{1'b0}};
            r_dma_cnt  <= {LEN_W{1'b0}};
            r_wire_cnt <= {LEN_W{1'b0}};
            r_byte_ph  <= 1'b0;
            r_rx_hi    <= 8'h00;
            r_addr     <= {ADDR_W{1'b0}};
        end else if (clear) begin
            r_len      <= {LEN_W{1'b0}};
            r_dma_cnt  <= {LEN_W{1'b0}};
            r_wire_cnt <= {LEN_W{1'b0}};
            r_byte_ph  <= 1'b0;
            r_rx_hi    <= 8'h00;
            r_addr     <= {ADDR_W{1'b0}};
        end else if (r_state == S_IDLE) begin
            if (start) begin
                r_len      <= w_len_eff;
                r_addr     <= mem_addr;
                r_dma_cnt  <= {LEN_W{1'b0}};
                r_wire_cnt <= {LEN_W{1'b0}};
                r_byte_ph  <= 1'b0;
            end
        end else begin
            if (w_dma_fire) begin
                r_addr    <= r_addr + ADDR_W'(1);
                r_dma_cnt <= r_dma_cnt + LEN_W'(1);
            end
            if (w_rx_fire || w_tx_fire) begin
                r_byte_ph <= ~r_byte_ph;
                if (w_rx_fire && !r_byte_ph) r_rx_hi <= rx_data;
                if (r_byte_ph && w_data_ph)  r_wire_cnt <= r_wire_cnt + LEN_W'(1);
            end
        end
    end

    // FIFO pointers; the FIFO is emptied whenever no transfer phase uses it,
    // which also discards words received beyond len on a partial read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wp  <= {PTR_W{1'b0}};
            r_rp  <= {PTR_W{1'b0}};
            r_cnt <= {(PTR_W + 1){1'b0}};
        end else if (clear || !((r_state == S_RD_XFER) || (r_state == S_WR_XFER))) begin
            r_wp  <= {PTR_W{1'b0}};
            r_rp  <= {PTR_W{1'b0}};
            r_cnt <= {(PTR_W + 1){1'b0}};
        end else begin
            if (w_push) r_wp <= r_wp + PTR_W'(1);
            if (w_pop)  r_rp <= r_rp + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + (PTR_W + 1)'(1);
                2'b01:   r_cnt <= r_cnt - (PTR_W + 1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // FIFO storage; contents are don't-care while the pointers say empty.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= (r_state == S_RD_XFER) ? w_rx_word : dmaDIN;
    end

`ifdef SD_XFER_CRC_EN
    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] x;
        logic        fb;
        x = c;
        for (int i = 7; i >= 0; i--) begin
            fb = x[15] ^ d[i];
            x  = {x[14:0], 1'b0};
            if (fb) x = x ^ 16'h1021;
        end
        return x;
    endfunction

    // CRC over data bytes in either direction; check on the second read CRC byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_crc     <= 16'h0000;
            r_crc_err <= 1'b0;
        end else if (clear) begin
            r_crc     <= 16'h0000;
            r_crc_err <= 1'b0;
        end else if ((r_state == S_IDLE) && start) begin
            r_crc     <= 16'h0000;
            r_crc_err <= 1'b0;
        end else if (w_rx_fire && w_data_ph) begin
            r_crc <= crc16_byte(r_crc, rx_data);
        end else if (w_rx_fire && (r_state == S_RD_CRC) && r_byte_ph) begin
            r_crc_err <= ({r_rx_hi, rx_data} != r_crc);
        end else if (w_tx_fire && w_data_ph) begin
            r_crc <= crc16_byte(r_crc, tx_data);
        end
    end

    assign crc_err = r_crc_err;
`else
    assign crc_err = 1'b0;
`endif

endmodule

// File: tb/tb_sd_sector_xfer.sv
module tb_sd_sector_xfer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic        start = 1'b0;
    logic        dir = 1'b0;
    logic [14:0] mem_addr = 15'd0;
    logic [8:0]  len = 9'd0;
    logic [11:0] dmaDIN;
    logic [11:0] dmaDOUT;
    logic [14:0] dmaADDR;
    logic        dmaRD, dmaWR, dmaREQ;
    logic        dmaGNT = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        busy, done, crc_err;

    int n_total = 0;
    int n_bad   = 0;
    int n_done  = 0;
    int n_rd    = 0;
    int rd_first = 0;
    int rd_last  = 0;
    int cyc     = 0;
    int din_mode = 0;
    bit gnt_rand = 1'b0;
    bit rdy_rand = 1'b0;

    logic [26:0] q_dw[$];   // expected {addr, data} per DMA write
    logic [14:0] q_dr[$];   // expected address per DMA read
    logic [7:0]  q_tx[$];   // expected transmitted bytes
    logic [26:0] mon_e;

    sd_sector_xfer dut (
        .clk(clk), .reset(reset), .clear(clear), .start(start), .dir(dir),
        .mem_addr(mem_addr), .len(len), .dmaDIN(dmaDIN), .dmaDOUT(dmaDOUT),
        .dmaADDR(dmaADDR), .dmaRD(dmaRD), .dmaWR(dmaWR), .dmaREQ(dmaREQ),
        .dmaGNT(dmaGNT), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .done(done), .crc_err(crc_err)
    );

    always #5 clk = ~clk;

    // memory model: data depends on the address presented
    assign dmaDIN = (din_mode == 1) ? (dmaADDR[11:0] ^ 12'o1234) :
                    (din_mode == 2) ? 12'o0000 : 12'o5252;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] x;
        x = c;
        for (int i = 7; i >= 0; i--) begin
            logic fb;
            fb = x[15] ^ d[i];
            x = {x[14:0], 1'b0};
            if (fb) x = x ^ 16'h1021;
        end
        return x;
    endfunction

    function automatic int eff_len(input logic [8:0] l);
        return ((l == 9'd0) || (l > 9'd256)) ? 256 : int'(l);
    endfunction

    // scoreboard side: compare DUT outputs against queued expectations
    always @(negedge clk) begin
        cyc++;
        if (done) n_done++;
        if (dmaRD && dmaWR) chk("rd_wr_both", 32'd1, 32'd0);
        if (dmaWR) begin
            if (q_dw.size() == 0) chk("dw_extra", 32'd1, 32'd0);
            else begin
                mon_e = q_dw.pop_front();
                chk("dw_addr", 32'(dmaADDR), 32'(mon_e[26:12]));
                chk("dw_data", 32'(dmaDOUT), 32'(mon_e[11:0]));
            end
        end
        if (dmaRD) begin
            n_rd++;
            if (n_rd == 1) rd_first = cyc;
            rd_last = cyc;
            if (q_dr.size() == 0) chk("dr_extra", 32'd1, 32'd0);
            else chk("dr_addr", 32'(dmaADDR), 32'(q_dr.pop_front()));
        end
        if (tx_valid && tx_ready) begin
            if (q_tx.size() == 0) chk("tx_extra", 32'd1, 32'd0);
            else chk("tx_byte", 32'(tx_data), 32'(q_tx.pop_front()));
        end
    end

    // background grant / tx-ready drivers
    initial begin
        forever begin
            @(posedge clk);
            #1;
            dmaGNT   = gnt_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
            tx_ready = rdy_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        rx_data = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (rx_ready) ok = 1'b1;
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end else begin
            chk("rx_timeout", 32'd0, 32'd1);
        end
        rx_valid = 1'b0;
    endtask

    task automatic do_start(input logic d, input logic [14:0] a, input logic [8:0] l);
        dir = d; mem_addr = a; len = l;
        n_done = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 5000 && !idle; i++) begin
            @(negedge clk);
            if (!busy) idle = 1'b1;
        end
        chk({tag, "_idle"}, 32'(idle), 32'd1);
        chk({tag, "_done_cnt"}, 32'(n_done), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [14:0] a, input logic [8:0] l, input bit pat,
                           input bit bad_crc, input string tag);
        int n;
        logic [11:0] w;
        logic [7:0] hi, lo;
        logic [15:0] crc;
        n = eff_len(l);
        crc = 16'h0000;
        do_start(1'b0, a, l);
        for (int k = 0; k < 256; k++) begin
            w  = pat ? 12'($urandom) : 12'o5252;
            hi = {pat ? 4'($urandom) : 4'h0, w[11:8]};
            lo = w[7:0];
            if (k < n) q_dw.push_back({15'(a + 15'(k)), w});
            crc = crc_upd(crc_upd(crc, hi), lo);
            send_byte(hi);
            if (k == 255) begin
                chk({tag, "_busy_b511"}, 32'(busy), 32'd1);
                chk({tag, "_nodone_b511"}, 32'(n_done), 32'd0);
            end
            send_byte(lo);
        end
`ifdef SD_XFER_CRC_EN
        send_byte(crc[15:8]);
        send_byte(crc[7:0] ^ (bad_crc ? 8'h01 : 8'h00));
`endif
        wait_done(tag);
        chk({tag, "_dw_left"}, 32'(q_dw.size()), 32'd0);
`ifdef SD_XFER_CRC_EN
        chk({tag, "_crc_err"}, 32'(crc_err), 32'(bad_crc));
`else
        chk({tag, "_crc_err"}, 32'(crc_err), {31'd0, 1'b0 & bad_crc});
`endif
    endtask

    task automatic push_write_exp(input logic [14:0] a, input logic [8:0] l, input int mode);
        int n;
        logic [14:0] ad;
        logic [11:0] w;
        logic [15:0] crc;
        n = eff_len(l);
        crc = 16'h0000;
        for (int k = 0; k < 256; k++) begin
            if (k < n) begin
                ad = 15'(a + 15'(k));
                q_dr.push_back(ad);
                w = (mode == 1) ? (ad[11:0] ^ 12'o1234) : (mode == 2) ? 12'o0000 : 12'o5252;
            end else begin
                w = 12'o0000;
            end
            q_tx.push_back({4'h0, w[11:8]});
            q_tx.push_back(w[7:0]);
            crc = crc_upd(crc_upd(crc, {4'h0, w[11:8]}), w[7:0]);
        end
`ifdef SD_XFER_CRC_EN
        q_tx.push_back(crc[15:8]);
        q_tx.push_back(crc[7:0]);
`else
        crc = 16'h0000;
`endif
    endtask

    task automatic do_write(input logic [14:0] a, input logic [8:0] l, input int mode,
                            input string tag);
        din_mode = mode;
        push_write_exp(a, l, mode);
        do_start(1'b1, a, l);
        wait_done(tag);
        chk({tag, "_dr_left"}, 32'(q_dr.size()), 32'd0);
        chk({tag, "_tx_left"}, 32'(q_tx.size()), 32'd0);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_busy"},   32'(busy),     32'd0);
        chk({tag, "_req"},    32'(dmaREQ),   32'd0);
        chk({tag, "_rdwr"},   32'({dmaRD, dmaWR}), 32'd0);
        chk({tag, "_rxrdy"},  32'(rx_ready), 32'd0);
        chk({tag, "_txv"},    32'(tx_valid), 32'd0);
        chk({tag, "_done"},   32'(done),     32'd0);
        chk({tag, "_addr"},   32'(dmaADDR),  32'd0);
        chk({tag, "_crcerr"}, 32'(crc_err),  32'd0);
    endtask

    initial begin
        tick();
        tick();
        chk_quiet("rst");
        reset = 1'b0;
        tick();

        // full-sector read, constant pattern
        do_read(15'o00000, 9'd0, 1'b0, 1'b0, "t1");
        // partial read crossing the address wrap, random data with junk upper nibble
        gnt_rand = 1'b1;
        do_read(15'o77700, 9'd128, 1'b1, 1'b0, "t2");
        // oversize length behaves as a full sector
        do_read(15'o01000, 9'd300, 1'b1, 1'b0, "t2b");

        // partial write with backpressure on both sides
        rdy_rand = 1'b1;
        do_write(15'o00200, 9'd128, 0, "t3");
        // full write with address-dependent data across the wrap
        do_write(15'o77700, 9'd0, 1, "t3b");

        // address wrap with grant held: four consecutive read strobes
        gnt_rand = 1'b0;
        rdy_rand = 1'b0;
        n_rd = 0;
        do_write(15'o77776, 9'd4, 0, "t4");
        chk("t4_nrd", 32'(n_rd), 32'd4);
        chk("t4_consec", 32'(rd_last - rd_first), 32'd3);

        // clear after ten read words
        do_start(1'b0, 15'o00000, 9'd0);
        for (int k = 0; k < 10; k++) begin
            q_dw.push_back({15'(k), 12'o5252});
            send_byte(8'h0A);
            send_byte(8'hAA);
        end
        tick(); tick(); tick();
        chk("t5_dw_left", 32'(q_dw.size()), 32'd0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk_quiet("t5_clr");
        for (int i = 0; i < 5; i++) tick();
        chk("t5_clr_nodone", 32'(n_done), 32'd0);

        // reset in the middle of a write
        rdy_rand = 1'b1;
        din_mode = 0;
        push_write_exp(15'o00400, 9'd128, 0);
        do_start(1'b1, 15'o00400, 9'd128);
        for (int i = 0; i < 40; i++) tick();
        chk("t5_wr_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk_quiet("t5_rst");
        tick();
        reset = 1'b0;
        q_dr.delete();
        q_tx.delete();
        for (int i = 0; i < 5; i++) tick();
        chk("t5_rst_nodone", 32'(n_done), 32'd0);
        rdy_rand = 1'b0;

        // a new command after the aborts
        do_read(15'o00000, 9'd0, 1'b0, 1'b0, "t5_new");

`ifdef SD_XFER_CRC_EN
        do_write(15'o00000, 9'd0, 2, "t6w");
        do_read(15'o00000, 9'd0, 1'b1, 1'b1, "t6r");
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
